flex_stp_framer: RTL and testbench

- Parametrised serial-to-parallel shift register with a selectable shift direction and a bit counter that detects word boundaries.
- Each completed NUM_BITS-bit word is copied into a holding register and presented with a valid/ack handshake.
- An overrun occurs when a new word completes while the previous one is unacknowledged; it is flagged sticky.
- Sits behind serial receivers (UART/SPI-style front ends) and feeds word-oriented consumers.

---
 rtl/flex_stp_framer.sv | 101 ++++++++++
 tb/tb_flex_stp_framer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/flex_stp_framer.sv
// Serial-to-parallel framer: a shift register with a selectable direction, a bit counter
// that marks word boundaries, and a holding register with a valid/ack handshake and sticky overrun.
module flex_stp_framer #(
    parameter int NUM_BITS  = 4,
    parameter bit SHIFT_MSB = 1'b1,
    parameter int CW        = $clog2(NUM_BITS)
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                shift_enable,
    input  logic                serial_in,
    input  logic                clear,
    input  logic                word_ack,
    output logic [NUM_BITS-1:0] parallel_out,
    output logic [NUM_BITS-1:0] word_out,
    output logic                word_valid,
    output logic [CW-1:0]       bit_count,
    output logic                overrun
);

    logic [NUM_BITS-1:0] shift_q, shift_d, shifted;
    logic [CW-1:0]       count_q, count_d;
    logic [NUM_BITS-1:0] word_q, word_d;
    logic                valid_q, valid_d;
    logic                overrun_q, overrun_d;
    logic                complete;

    always_comb begin
        if (SHIFT_MSB) begin
            shifted = {serial_in, shift_q[NUM_BITS-1:1]};
        end else begin
            shifted = {shift_q[NUM_BITS-2:0], serial_in};
        end
    end

    always_comb begin
        shift_d  = shift_q;
        count_d  = count_q;
        complete = 1'b0;
        if (clear) begin
            shift_d = '1;
            count_d = '0;
        end else if (shift_enable) begin
            shift_d = shifted;
            if (count_q == CW'(NUM_BITS - 1)) begin
                count_d  = '0;
                complete = 1'b1;
            end else begin
                count_d = count_q + CW'(1);
            end
        end
    end

    // Completion takes precedence over ack: a coincident ack consumes the old word only.
    always_comb begin
        word_d    = word_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (complete) begin
            word_d  = shifted;
            valid_d = 1'b1;
            if (valid_q && !word_ack) begin
                overrun_d = 1'b1;
            end
        end else if (word_ack && valid_q) begin
            valid_d = 1'b0;
        end
        if (clear) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            shift_q <= '1;
            count_q <= '0;
        end else begin
            shift_q <= shift_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            word_q    <= '1;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            word_q    <= word_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign parallel_out = shift_q;
    assign word_out     = word_q;
    assign word_valid   = valid_q;
    assign bit_count    = count_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_flex_stp_framer.sv
// Self-checking bench: a 4-bit MSB-entry framer and an 8-bit LSB-entry framer share one bit stream
// and are compared against a bit-history reference model.
module tb_flex_stp_framer;

    logic clk = 1'b0, n_rst = 1'b0;
    logic se = 1'b0, si = 1'b0, clr = 1'b0, ack = 1'b0;
    logic [3:0] po4, wo4;
    logic [1:0] bc4;
    logic       wv4, ov4;
    logic [7:0] po8, wo8;
    logic [2:0] bc8;
    logic       wv8, ov8;

    int tests = 0;
    int fails = 0;

    // Reference state per framer: hist[d][k] is the bit accepted k shifts ago (ones when unfilled).
    bit         hist[2][8];
    int         cnt[2];
    logic [7:0] mword[2];
    bit         mvalid[2];
    bit         movr[2];

    always #5 clk = ~clk;

    flex_stp_framer #(.NUM_BITS(4), .SHIFT_MSB(1'b1)) dut4 (
        .clk(clk), .n_rst(n_rst), .shift_enable(se), .serial_in(si), .clear(clr),
        .word_ack(ack), .parallel_out(po4), .word_out(wo4), .word_valid(wv4),
        .bit_count(bc4), .overrun(ov4));

    flex_stp_framer #(.NUM_BITS(8), .SHIFT_MSB(1'b0)) dut8 (
        .clk(clk), .n_rst(n_rst), .shift_enable(se), .serial_in(si), .clear(clr),
        .word_ack(ack), .parallel_out(po8), .word_out(wo8), .word_valid(wv8),
        .bit_count(bc8), .overrun(ov8));

    function automatic int nbits(int d);
        return (d == 0) ? 4 : 8;
    endfunction

    // MSB entry: newest bit sits in the MSB; LSB entry: newest bit sits in the LSB.
    function automatic logic [7:0] mpar(int d);
        logic [7:0] w;
        int n;
        w = 8'h00;
        n = nbits(d);
        for (int k = 0; k < n; k++) begin
            if (d == 0) w[n-1-k] = hist[d][k];
            else        w[k]     = hist[d][k];
        end
        return w;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 8; k++) hist[d][k] = 1'b1;
            cnt[d]    = 0;
            mword[d]  = 8'hFF;
            mvalid[d] = 1'b0;
            movr[d]   = 1'b0;
        end
    endtask

    task automatic model_edge(bit e, bit b, bit c, bit a);
        for (int d = 0; d < 2; d++) begin
            bit done;
            done = 1'b0;
            if (c) begin
                for (int k = 0; k < 8; k++) hist[d][k] = 1'b1;
                cnt[d]  = 0;
                movr[d] = 1'b0;
            end else if (e) begin
                for (int k = 7; k > 0; k--) hist[d][k] = hist[d][k-1];
                hist[d][0] = b;
                cnt[d] = cnt[d] + 1;
                if (cnt[d] == nbits(d)) begin
                    cnt[d] = 0;
                    done = 1'b1;
                    if (mvalid[d] && !a) movr[d] = 1'b1;
                    mword[d]  = mpar(d);
                    mvalid[d] = 1'b1;
                end
            end
            if (!done && a && mvalid[d]) mvalid[d] = 1'b0;
        end
    endtask

    // One clock: drive inputs, let the edge pass, advance the model, return inputs to idle.
    task automatic cycle(bit e, bit b, bit c, bit a);
        se = e; si = b; clr = c; ack = a;
        @(posedge clk);
        #1;
        model_edge(e, b, c, a);
        se = 1'b0; si = 1'b0; clr = 1'b0; ack = 1'b0;
    endtask

    task automatic do_reset();
        n_rst = 1'b0;
        #2;
        model_reset();
        n_rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        @(posedge clk); #1;
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        #2;
        n_rst = 1'b0;
        #1;
        tests++; if (po4 !== 4'hF) begin fails++; $display("FAIL reset_po4 got=%h exp=f", po4); end
        tests++; if (wo4 !== 4'hF) begin fails++; $display("FAIL reset_wo4 got=%h exp=f", wo4); end
        tests++; if (po8 !== 8'hFF) begin fails++; $display("FAIL reset_po8 got=%h exp=ff", po8); end
        tests++; if ({wv4, ov4, bc4} !== 4'b0) begin fails++; $display("FAIL reset_flags4 got=%b exp=0000", {wv4, ov4, bc4}); end
        tests++; if ({wv8, ov8, bc8} !== 5'b0) begin fails++; $display("FAIL reset_flags8 got=%b exp=00000", {wv8, ov8, bc8}); end
        model_reset();
        #1 n_rst = 1'b1;
    endtask

    task automatic test_msb_word();
        bit bits[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, bits[i], 1'b0, 1'b0);
            if (i < 3) begin
                cycle(1'b0, 1'b0, 1'b0, 1'b0);
                cycle(1'b0, 1'b1, 1'b0, 1'b0);
            end
        end
        tests++; if (po4 !== 4'b1101) begin fails++; $display("FAIL msb_po got=%b exp=1101", po4); end
        tests++; if (wo4 !== 4'b1101) begin fails++; $display("FAIL msb_word got=%b exp=1101", wo4); end
        tests++; if (wv4 !== 1'b1) begin fails++; $display("FAIL msb_valid got=%b exp=1", wv4); end
        tests++; if (bc4 !== 2'd0) begin fails++; $display("FAIL msb_count got=%0d exp=0", bc4); end
    endtask

    task automatic test_lsb_word();
        logic [7:0] v;
        v = 8'hA5;
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 7; i >= 0; i--) cycle(1'b1, v[i], 1'b0, 1'b0);
        tests++; if (wo8 !== 8'hA5 || wv8 !== 1'b1) begin fails++; $display("FAIL lsb_word got=%h/%b exp=a5/1", wo8, wv8); end
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        tests++; if (wv8 !== 1'b0) begin fails++; $display("FAIL lsb_ack_valid got=%b exp=0", wv8); end
        tests++; if (wo8 !== 8'hA5) begin fails++; $display("FAIL lsb_ack_word got=%h exp=a5", wo8); end
    endtask

    task automatic test_overrun();
        bit bits[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, bits[i], 1'b0, 1'b0);
            if (i == 3) begin
                tests++; if (wo4 !== 4'h3) begin fails++; $display("FAIL ovr_first got=%h exp=3", wo4); end
            end
        end
        tests++; if (wo4 !== 4'hC || wv4 !== 1'b1 || ov4 !== 1'b1) begin fails++; $display("FAIL ovr_set got=%h/%b/%b exp=c/1/1", wo4, wv4, ov4); end
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        tests++; if (wv4 !== 1'b0 || ov4 !== 1'b1) begin fails++; $display("FAIL ovr_ack got=%b/%b exp=0/1", wv4, ov4); end
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        tests++; if (ov4 !== 1'b0) begin fails++; $display("FAIL ovr_clear got=%b exp=0", ov4); end
    endtask

    task automatic test_back_to_back();
        bit bits[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1'b1, bits[i], 1'b0, (i == 7));
        tests++; if (wv4 !== 1'b1) begin fails++; $display("FAIL simul_valid got=%b exp=1", wv4); end
        tests++; if (wo4 !== 4'hE) begin fails++; $display("FAIL simul_word got=%h exp=e", wo4); end
        tests++; if (ov4 !== 1'b0) begin fails++; $display("FAIL simul_ovr got=%b exp=0", ov4); end
    endtask

    task automatic test_clear_midword();
        bit bits[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        tests++; if (bc4 !== 2'd0 || po4 !== 4'hF) begin fails++; $display("FAIL clr_shift got=%0d/%h exp=0/f", bc4, po4); end
        tests++; if (wv4 !== 1'b1 || wo4 !== 4'hE) begin fails++; $display("FAIL clr_hold got=%b/%h exp=1/e", wv4, wo4); end
        for (int i = 0; i < 4; i++) cycle(1'b1, bits[i], 1'b0, 1'b0);
        tests++; if (wo4 !== 4'h2) begin fails++; $display("FAIL clr_word got=%h exp=2", wo4); end
    endtask

    task automatic test_random();
        logic [7:0] e4, e8, m4, m8;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            cycle($urandom_range(9, 0) < 7, $urandom_range(1, 0) == 1,
                  $urandom_range(19, 0) == 0, $urandom_range(4, 0) == 0);
            e4 = mpar(0); e8 = mpar(1); m4 = mword[0]; m8 = mword[1];
            tests++;
            if (po4 !== e4[3:0] || wo4 !== m4[3:0] || wv4 !== mvalid[0] || ov4 !== movr[0] || bc4 !== 2'(cnt[0])) begin
                fails++;
                $display("FAIL rnd4 cyc=%0d got po=%h wo=%h v=%b o=%b c=%0d exp po=%h wo=%h v=%b o=%b c=%0d",
                         n, po4, wo4, wv4, ov4, bc4, e4[3:0], m4[3:0], mvalid[0], movr[0], cnt[0]);
            end
            tests++;
            if (po8 !== e8 || wo8 !== m8 || wv8 !== mvalid[1] || ov8 !== movr[1] || bc8 !== 3'(cnt[1])) begin
                fails++;
                $display("FAIL rnd8 cyc=%0d got po=%h wo=%h v=%b o=%b c=%0d exp po=%h wo=%h v=%b o=%b c=%0d",
                         n, po8, wo8, wv8, ov8, bc8, e8, m8, mvalid[1], movr[1], cnt[1]);
            end
        end
    endtask

    initial begin
        model_reset();
        #1;
        test_reset();
        test_msb_word();
        test_lsb_word();
        test_overrun();
        test_back_to_back();
        test_clear_midword();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
